// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue stage and muldiv_unit.
// The master drives the operation; the slave (muldiv_unit) returns the write-back pair.
interface muldiv_unit_if #(
    parameter int unsigned N = 32
);
    logic         start;
    logic [2:0]   funct3;
    logic [N-1:0] rs1_val;
    logic [N-1:0] rs2_val;
    logic [4:0]   rd_in;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [4:0]   rd_out;

    modport master (
        output start, funct3, rs1_val, rs2_val, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV-style multiply/divide unit: shift-add multiply, restoring divide, N cycles per op.
// Define MULDIV_FAST_MUL_EN to compute multiplies combinationally in a single CALC cycle.
module muldiv_unit #(
    parameter int unsigned N = 32
) (
    input logic         clk,
    input logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     op_q;
    logic [4:0]     rd_q;
    logic [N-1:0]   opa_q;
    logic [N-1:0]   opb_q;
    logic [2*N:0]   acc_q, acc_d;
    logic           neg_q, dzero_q;
    logic [N-1:0]   result_q, result_d;
    logic [4:0]     rd_out_q, rd_out_d;
    logic           load;

    // Operand conditioning at acceptance: everything runs on magnitudes.
    logic           a_signed, b_signed, a_neg, b_neg, in_div;
    logic [N-1:0]   a_mag, b_mag;

    assign in_div   = bus.funct3[2];
    assign a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b110);
    assign a_neg    = a_signed & bus.rs1_val[N-1];
    assign b_neg    = b_signed & bus.rs2_val[N-1];
    assign a_mag    = a_neg ? -bus.rs1_val : bus.rs1_val;
    assign b_mag    = b_neg ? -bus.rs2_val : bus.rs2_val;

    // acc holds {partial product/remainder, multiplier/quotient}.
    logic [2*N:0]   mul_nxt, div_nxt, acc_nxt;
    logic [N:0]     rem_sh, diff;
    logic           fast_mul;

`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul = 1'b1;
    assign mul_nxt  = {1'b0, {{N{1'b0}}, opb_q} * {{N{1'b0}}, acc_q[N-1:0]}};
`else
    logic [N:0]     madd;
    assign fast_mul = 1'b0;
    assign madd     = acc_q[2*N:N] + (acc_q[0] ? {1'b0, opb_q} : {(N+1){1'b0}});
    assign mul_nxt  = {1'b0, madd, acc_q[N-1:1]};
`endif

    assign rem_sh  = {acc_q[2*N-1:N], acc_q[N-1]};
    assign diff    = rem_sh - {1'b0, opb_q};
    assign div_nxt = diff[N] ? {rem_sh, acc_q[N-2:0], 1'b0} : {diff, acc_q[N-2:0], 1'b1};
    assign acc_nxt = op_q[2] ? div_nxt : mul_nxt;

    logic [2*N-1:0] prod;
    logic [N-1:0]   quo, rem, final_res;
    logic           finish;

    assign prod   = neg_q ? -acc_nxt[2*N-1:0] : acc_nxt[2*N-1:0];
    assign quo    = dzero_q ? {N{1'b1}} : (neg_q ? -acc_nxt[N-1:0] : acc_nxt[N-1:0]);
    assign rem    = dzero_q ? opa_q : (neg_q ? -acc_nxt[2*N-1:N] : acc_nxt[2*N-1:N]);
    assign finish = (cnt_q == CW'(N - 1)) || (fast_mul && !op_q[2]);

    always_comb begin
        final_res = quo;
        case (op_q)
            3'b000:                   final_res = prod[N-1:0];
            3'b001, 3'b010, 3'b011:   final_res = prod[2*N-1:N];
            3'b100, 3'b101:           final_res = quo;
            default:                  final_res = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        load     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                cnt_d = cnt_q + CW'(1);
                acc_d = acc_nxt;
                if (finish) begin
                    state_d  = StDone;
                    result_d = final_res;
                    rd_out_d = rd_q;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            dzero_q  <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            if (load) begin
                op_q    <= bus.funct3;
                rd_q    <= bus.rd_in;
                opa_q   <= bus.rs1_val;
                opb_q   <= in_div ? b_mag : a_mag;
                acc_q   <= {{(N+1){1'b0}}, (in_div ? a_mag : b_mag)};
                // Remainder follows the dividend sign; products and quotients the sign product.
                neg_q   <= (bus.funct3[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);
                dzero_q <= (bus.rs2_val == '0);
            end else begin
                acc_q   <= acc_d;
            end
        end
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops vs. an arithmetic
// model, and hand sequences for ignored start, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;
    localparam int unsigned N = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_unit_if #(.N(N)) bus ();
    muldiv_unit #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [2:0] f);
`ifdef MULDIV_FAST_MUL_EN
        return f[2] ? 32 : 1;
`else
        return 32;
`endif
    endfunction

    // Reference: 64-bit language arithmetic plus the architectural divide corner rules.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op from IDLE and wait for done; inputs are scrambled right after acceptance.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res,
                          output logic [4:0] rdo, output int lat);
        bus.funct3  = f;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd_in   = rd;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
        bus.rd_in   = 5'($urandom);
        bus.funct3  = 3'($urandom);
        chk("busy_after_accept", 64'(bus.busy), 64'd1);
        lat = 0;
        while (!bus.done && lat < 100) begin
            tick();
            lat++;
        end
        res = bus.result;
        rdo = bus.rd_out;
        if (bus.done) begin
            tick();
            chk("done_one_cycle", 64'(bus.done), 64'd0);
            chk("busy_low_after_done", 64'(bus.busy), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] res, a, b;
        logic [4:0]  rdo;
        logic [2:0]  f;
        int          lat, ndone;

        vt[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        vt[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
        vt[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000};
        vt[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF};
        vt[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD};
        vt[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF};
        vt[6]  = '{3'd5, 32'd100,        32'd7,         5'd7,  32'd14};
        vt[7]  = '{3'd7, 32'd100,        32'd7,         5'd0,  32'd2};
        vt[8]  = '{3'd5, 32'd5,          32'd0,         5'd8,  32'hFFFF_FFFF};
        vt[9]  = '{3'd6, 32'd5,          32'd0,         5'd31, 32'd5};
        vt[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000};
        vt[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h0};

        // Reset wins over a simultaneous start.
        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.funct3  = 3'd0;
        bus.rs1_val = 32'd3;
        bus.rs2_val = 32'd4;
        bus.rd_in   = 5'd9;
        tick();
        tick();
        chk("reset_busy",   64'(bus.busy),   64'd0);
        chk("reset_done",   64'(bus.done),   64'd0);
        chk("reset_result", 64'(bus.result), 64'd0);
        chk("reset_rd_out", 64'(bus.rd_out), 64'd0);
        bus.start = 1'b0;
        reset     = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_op(vt[i].f, vt[i].a, vt[i].b, vt[i].rd, res, rdo, lat);
            chk($sformatf("vec%0d_result", i), 64'(res), 64'(vt[i].exp));
            chk($sformatf("vec%0d_rd", i), 64'(rdo), 64'(vt[i].rd));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vt[i].f)));
        end

        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom);
            a = pick();
            b = pick();
            run_op(f, a, b, 5'(i), res, rdo, lat);
            chk($sformatf("rand%0d_f%0d_result", i, f), 64'(res), 64'(model(f, a, b)));
            chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(exp_lat(f)));
        end

        // A second start three cycles into CALC is ignored.
        bus.funct3  = 3'd3;
        bus.rs1_val = 32'hFFFF_FFFF;
        bus.rs2_val = 32'hFFFF_FFFF;
        bus.rd_in   = 5'd9;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0;
        repeat (2) begin
            tick();
            lat++;
        end
        bus.funct3  = 3'd5;
        bus.rs1_val = 32'd100;
        bus.rs2_val = 32'd7;
        bus.rd_in   = 5'd3;
        bus.start   = 1'b1;
        tick();
        lat++;
        bus.start = 1'b0;
        while (!bus.done && lat < 100) begin
            tick();
            lat++;
        end
        chk("ignore_start_result",  64'(bus.result), 64'h0000_0000_FFFF_FFFE);
        chk("ignore_start_rd",      64'(bus.rd_out), 64'd9);
        chk("ignore_start_latency", 64'(lat),        64'(exp_lat(3'd3)));
        tick();
        // Issue immediately once back in IDLE.
        run_op(3'd5, 32'd100, 32'd7, 5'd3, res, rdo, lat);
        chk("back_to_back_result", 64'(res), 64'd14);
        chk("back_to_back_rd",     64'(rdo), 64'd3);

        // Reset at the 10th CALC edge aborts with no done pulse.
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, res, rdo, lat);
        bus.funct3  = 3'd4;
        bus.rs1_val = 32'd1000;
        bus.rs2_val = 32'd3;
        bus.rd_in   = 5'd12;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy",   64'(bus.busy),   64'd0);
        chk("abort_done",   64'(bus.done),   64'd0);
        chk("abort_result", 64'(bus.result), 64'd0);
        chk("abort_rd_out", 64'(bus.rd_out), 64'd0);
        ndone = 0;
        repeat (40) begin
            tick();
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
